// File: rtl/rr_enc_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant and encoded index.
// Grants stick while the owner keeps requesting, bounded by MAX_HOLD under contention.
module rr_enc_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] IDX,
  output logic       VALID
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StOwned = 1'b1;

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  logic [0:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic       valid_q, valid_d;

  logic [1:0] owner_next;
  logic [3:0] others;
  logic [3:0] pick_req;
  logic [1:0] pick_start;
  logic [2:0] pick_res;

  // Returns {found, index} of the first set bit of r starting at position start.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] p;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      p = start + 2'(k);
      if (r[p]) res = {1'b1, p};
    end
    return res;
  endfunction

  // IDX always holds the current owner while in StOwned.
  assign owner_next = idx_q + 2'd1;
  assign others     = REQ & ~(4'b0001 << idx_q);
  assign pick_req   = (state_q == StIdle) ? REQ : others;
  assign pick_start = (state_q == StIdle) ? ptr_q : owner_next;
  assign pick_res   = pick(pick_req, pick_start);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (pick_res[2]) begin
          gnt_d   = 4'b0001 << pick_res[1:0];
          idx_d   = pick_res[1:0];
          valid_d = 1'b1;
          hold_d  = 8'd0;
          state_d = StOwned;
        end
      end
      StOwned: begin
        if (!REQ[idx_q]) begin
          ptr_d = owner_next;
          if (pick_res[2]) begin
            gnt_d  = 4'b0001 << pick_res[1:0];
            idx_d  = pick_res[1:0];
            hold_d = 8'd0;
          end else begin
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end else if (hold_q == HoldLast && pick_res[2]) begin
          ptr_d  = owner_next;
          gnt_d  = 4'b0001 << pick_res[1:0];
          idx_d  = pick_res[1:0];
          hold_d = 8'd0;
        end else if (hold_q != HoldLast) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      hold_q  <= 8'd0;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign GNT   = gnt_q;
  assign IDX   = idx_q;
  assign VALID = valid_q;

endmodule
